// File: rtl/switch_debouncer.sv
// Two-flop synchroniser and stability counter per switch. Outputs the settled levels,
// one-cycle rise/fall pulses and a wrapping count of accepted changes.
module switch_debouncer #(
   parameter int N               = 6,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic         MAX10_CLK1_50,
   input  logic         KEY0,
   input  logic [0:N-1] SW,
   output logic [0:N-1] SW_CLEAN,
   output logic [0:N-1] SW_RISE,
   output logic [0:N-1] SW_FALL,
   output logic [7:0]   EVENT_CNT
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [0:N-1] w_accept;
   logic [7:0]   w_pop;
   logic [7:0]   r_event;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         logic             r_sync1;
         logic             r_sync2;
         logic             r_clean;
         logic             r_rise;
         logic             r_fall;
         logic [CNT_W-1:0] r_cnt;
         logic             w_diff;

         assign w_diff       = r_sync2 ^ r_clean;
         assign w_accept[gi] = w_diff && (r_cnt == LP_LAST);

         // A bounce back to the settled level clears the counter, so only an
         // unbroken run of the new level is ever accepted.
         always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
            if (!KEY0) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_clean <= 1'b0;
               r_rise  <= 1'b0;
               r_fall  <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= SW[gi];
               r_sync2 <= r_sync1;
               if (!w_diff || w_accept[gi])
                  r_cnt <= '0;
               else
                  r_cnt <= r_cnt + CNT_W'(1);
               if (w_accept[gi])
                  r_clean <= r_sync2;
               r_rise <= w_accept[gi] & r_sync2;
               r_fall <= w_accept[gi] & ~r_sync2;
            end
         end

         assign SW_CLEAN[gi] = r_clean;
         assign SW_RISE[gi]  = r_rise;
         assign SW_FALL[gi]  = r_fall;
      end
   endgenerate

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < N; i++)
         w_pop = w_pop + {7'd0, w_accept[i]};
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0)
         r_event <= '0;
      else
         r_event <= r_event + w_pop;
   end

   assign EVENT_CNT = r_event;

endmodule
